// File: rtl/serial_bus_fabric.sv
// rtl/serial_bus_fabric.sv - round-robin serial bus fabric with split transactions and ACK watchdog
module serial_bus_fabric #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_MASTERS-1:0] M_REQ,
  input  logic [NUM_MASTERS-1:0] M_UTIL,
  input  logic [NUM_MASTERS-1:0] M_ADD,
  input  logic [NUM_MASTERS-1:0] M_BUS_OUT,
  input  logic [NUM_MASTERS-1:0] M_RW,
  input  logic [NUM_MASTERS-1:0] M_DONE,
  output logic [NUM_MASTERS-1:0] M_GRANT,
  output logic [NUM_MASTERS-1:0] M_BUS_IN,
  output logic [NUM_MASTERS-1:0] M_READY,
  output logic [NUM_MASTERS-1:0] M_ACK,
  output logic [NUM_MASTERS-1:0] M_SPLIT,
  output logic [NUM_MASTERS-1:0] M_SPL_RESUME,
  output logic [NUM_SLAVES-1:0]  S_SEL,
  output logic [NUM_SLAVES-1:0]  S_BUS_OUT,
  output logic [NUM_SLAVES-1:0]  S_RW,
  input  logic [NUM_SLAVES-1:0]  S_BUS_IN,
  input  logic [NUM_SLAVES-1:0]  S_READY,
  input  logic [NUM_SLAVES-1:0]  S_ACK,
  input  logic [NUM_SLAVES-1:0]  S_SBSY,
  output logic                   ERR
);
  localparam int NM    = NUM_MASTERS;
  localparam int NS    = NUM_SLAVES;
  localparam int SEL_W = $clog2(NUM_SLAVES);
  localparam int MW    = $clog2(NUM_MASTERS);
  localparam int BW    = $clog2(SEL_W + 1);
  localparam int CW    = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, ADDR, ACK_WAIT, XFER} state_t;

  state_t            state, state_n;
  logic [NM-1:0]     grant, grant_n;
  logic [NS-1:0]     sel, sel_n;
  logic [MW-1:0]     g_idx, g_idx_n;
  logic [MW-1:0]     rr_ptr, rr_ptr_n;
  logic [SEL_W-1:0]  s_idx, s_idx_n;
  logic [SEL_W-1:0]  addr_sr, addr_sr_n;
  logic [BW-1:0]     bit_cnt, bit_cnt_n;
  logic [CW-1:0]     ack_cnt, ack_cnt_n;
  logic              split_vld, split_vld_n;
  logic [MW-1:0]     split_m, split_m_n;
  logic [SEL_W-1:0]  split_s, split_s_n;
  logic              err_q, err_n;
  logic [NM-1:0]     split_p, split_p_n;
  logic [NM-1:0]     resume_p, resume_p_n;

  logic [NM-1:0]     eligible;
  logic              arb_found;
  logic [MW-1:0]     arb_idx;
  logic [MW-1:0]     arb_cand;
  logic [SEL_W-1:0]  addr_next;

  // Index after shifting in the granted master's current address bit, MSB first
  assign addr_next = SEL_W'({addr_sr, M_ADD[g_idx]});

  // Round-robin pick: first eligible requester at or after rr_ptr; a parked split master is skipped
  always_comb begin
    eligible = M_REQ;
    if (split_vld) eligible[split_m] = 1'b0;
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cand  = '0;
    for (int i = 0; i < NM; i++) begin
      arb_cand = MW'((int'(rr_ptr) + i) % NM);
      if (!arb_found && eligible[arb_cand]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand;
      end
    end
  end

  // Next-state and next-register logic; pulses default low so they last one cycle
  always_comb begin
    state_n     = state;
    grant_n     = grant;
    sel_n       = sel;
    g_idx_n     = g_idx;
    rr_ptr_n    = rr_ptr;
    s_idx_n     = s_idx;
    addr_sr_n   = addr_sr;
    bit_cnt_n   = bit_cnt;
    ack_cnt_n   = ack_cnt;
    split_vld_n = split_vld;
    split_m_n   = split_m;
    split_s_n   = split_s;
    err_n       = 1'b0;
    split_p_n   = '0;
    resume_p_n  = '0;
    case (state)
      IDLE: begin
        if (split_vld && M_REQ[split_m] && !S_SBSY[split_s]) begin
          // Resume skips the address phase: the slave was already decoded before parking
          grant_n     = NM'(1) << split_m;
          sel_n       = NS'(1) << split_s;
          g_idx_n     = split_m;
          s_idx_n     = split_s;
          resume_p_n  = NM'(1) << split_m;
          split_vld_n = 1'b0;
          state_n     = XFER;
        end else begin
          if (split_vld && !M_REQ[split_m]) split_vld_n = 1'b0;
          if (arb_found) begin
            grant_n   = NM'(1) << arb_idx;
            g_idx_n   = arb_idx;
            addr_sr_n = '0;
            bit_cnt_n = '0;
            state_n   = ADDR;
          end
        end
      end
      ADDR: begin
        if (!M_REQ[g_idx]) begin
          grant_n   = '0;
          addr_sr_n = '0;
          bit_cnt_n = '0;
          state_n   = IDLE;
        end else if (M_UTIL[g_idx]) begin
          addr_sr_n = addr_next;
          bit_cnt_n = bit_cnt + BW'(1);
          if (int'(bit_cnt) == SEL_W - 1) begin
            if (int'(addr_next) < NS) begin
              sel_n     = NS'(1) << addr_next;
              s_idx_n   = addr_next;
              ack_cnt_n = '0;
              state_n   = ACK_WAIT;
            end else begin
              err_n   = 1'b1;
              grant_n = '0;
              state_n = IDLE;
            end
          end
        end
      end
      ACK_WAIT: begin
        // ack_cnt holds the number of ACK_WAIT cycles already completed
        ack_cnt_n = ack_cnt + CW'(1);
        if (S_ACK[s_idx]) begin
          state_n = XFER;
        end else if (S_SBSY[s_idx] && !split_vld) begin
          split_vld_n = 1'b1;
          split_m_n   = g_idx;
          split_s_n   = s_idx;
          split_p_n   = grant;
          grant_n     = '0;
          sel_n       = '0;
          state_n     = IDLE;
        end else if (int'(ack_cnt) == ACK_TIMEOUT - 1) begin
          err_n   = 1'b1;
          grant_n = '0;
          sel_n   = '0;
          state_n = IDLE;
        end
      end
      XFER: begin
        if (M_DONE[g_idx]) begin
          grant_n  = '0;
          sel_n    = '0;
          rr_ptr_n = MW'((int'(g_idx) + 1) % NM);
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers; reset also discards any parked split
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      grant     <= '0;
      sel       <= '0;
      g_idx     <= '0;
      rr_ptr    <= '0;
      s_idx     <= '0;
      addr_sr   <= '0;
      bit_cnt   <= '0;
      ack_cnt   <= '0;
      split_vld <= 1'b0;
      split_m   <= '0;
      split_s   <= '0;
      err_q     <= 1'b0;
      split_p   <= '0;
      resume_p  <= '0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      sel       <= sel_n;
      g_idx     <= g_idx_n;
      rr_ptr    <= rr_ptr_n;
      s_idx     <= s_idx_n;
      addr_sr   <= addr_sr_n;
      bit_cnt   <= bit_cnt_n;
      ack_cnt   <= ack_cnt_n;
      split_vld <= split_vld_n;
      split_m   <= split_m_n;
      split_s   <= split_s_n;
      err_q     <= err_n;
      split_p   <= split_p_n;
      resume_p  <= resume_p_n;
    end
  end

  // Point-to-point routing between the granted master and selected slave, only once a slave is selected
  always_comb begin
    S_BUS_OUT = '0;
    S_RW      = '0;
    M_BUS_IN  = '0;
    M_READY   = '0;
    M_ACK     = '0;
    if (state == ACK_WAIT || state == XFER) begin
      S_BUS_OUT[s_idx] = M_BUS_OUT[g_idx];
      S_RW[s_idx]      = M_RW[g_idx];
      M_BUS_IN[g_idx]  = S_BUS_IN[s_idx];
      M_READY[g_idx]   = S_READY[s_idx];
      M_ACK[g_idx]     = S_ACK[s_idx];
    end
  end

  assign M_GRANT      = grant;
  assign S_SEL        = sel;
  assign ERR          = err_q;
  assign M_SPLIT      = split_p;
  assign M_SPL_RESUME = resume_p;

endmodule

// File: tb/tb_serial_bus_fabric.sv
// tb/tb_serial_bus_fabric.sv - self-checking bench for serial_bus_fabric
module tb_serial_bus_fabric;
  localparam int NM     = 2;
  localparam int NS     = 3;
  localparam int ACK_TO = 16;
  localparam int SW     = $clog2(NS);

  logic          CLK, RST;
  logic [NM-1:0] M_REQ, M_UTIL, M_ADD, M_BUS_OUT, M_RW, M_DONE;
  logic [NM-1:0] M_GRANT, M_BUS_IN, M_READY, M_ACK, M_SPLIT, M_SPL_RESUME;
  logic [NS-1:0] S_SEL, S_BUS_OUT, S_RW, S_BUS_IN, S_READY, S_ACK, S_SBSY;
  logic          ERR;

  serial_bus_fabric #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ACK_TIMEOUT(ACK_TO)) dut (
    .CLK(CLK), .RST(RST),
    .M_REQ(M_REQ), .M_UTIL(M_UTIL), .M_ADD(M_ADD), .M_BUS_OUT(M_BUS_OUT),
    .M_RW(M_RW), .M_DONE(M_DONE),
    .M_GRANT(M_GRANT), .M_BUS_IN(M_BUS_IN), .M_READY(M_READY), .M_ACK(M_ACK),
    .M_SPLIT(M_SPLIT), .M_SPL_RESUME(M_SPL_RESUME),
    .S_SEL(S_SEL), .S_BUS_OUT(S_BUS_OUT), .S_RW(S_RW), .S_BUS_IN(S_BUS_IN),
    .S_READY(S_READY), .S_ACK(S_ACK), .S_SBSY(S_SBSY), .ERR(ERR)
  );

  typedef struct {
    logic [NM-1:0] req;
    int            idx;
    int            ack;
    bit            stall;
    logic [NM-1:0] exp_grant;
    logic [NS-1:0] exp_sel;
    bit            exp_err;
  } vec_t;

  vec_t tbl[8];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rr_model = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_winner(input logic [NM-1:0] rq);
    int c;
    model_winner = 0;
    for (int i = NM - 1; i >= 0; i--) begin
      c = (rr_model + i) % NM;
      if (rq[c]) model_winner = c;
    end
  endfunction

  task automatic clear_inputs();
    M_REQ = '0; M_UTIL = '0; M_ADD = '0; M_BUS_OUT = '0; M_RW = '0; M_DONE = '0;
    S_BUS_IN = '0; S_READY = '0; S_ACK = '0; S_SBSY = '0;
  endtask

  task automatic shift_idx(input int w, input int idx, input bit stall);
    for (int b = SW - 1; b >= 0; b--) begin
      if (stall) begin
        M_UTIL = ~(NM'(1) << w);
        M_ADD  = NM'($urandom);
        step();
        chk("sel_during_addr", 32'(S_SEL), 0);
      end
      M_UTIL = '1;
      M_ADD  = NM'($urandom);
      M_ADD[w] = 1'((idx >> b) & 1);
      step();
    end
    M_UTIL = '0;
    M_ADD  = '0;
  endtask

  task automatic xfer_route_done(input int w, input int idx);
    logic [NS-1:0] e_s, e_rw;
    logic [NM-1:0] e_bi, e_rd;
    for (int r = 0; r < 2; r++) begin
      M_BUS_OUT = NM'($urandom); M_RW = NM'($urandom);
      S_BUS_IN = NS'($urandom); S_READY = NS'($urandom);
      #1;
      e_s = '0; e_s[idx] = M_BUS_OUT[w];
      e_rw = '0; e_rw[idx] = M_RW[w];
      e_bi = '0; e_bi[w] = S_BUS_IN[idx];
      e_rd = '0; e_rd[w] = S_READY[idx];
      chk("route_s_bus_out", 32'(S_BUS_OUT), 32'(e_s));
      chk("route_s_rw", 32'(S_RW), 32'(e_rw));
      chk("route_m_bus_in", 32'(M_BUS_IN), 32'(e_bi));
      chk("route_m_ready", 32'(M_READY), 32'(e_rd));
    end
    M_BUS_OUT = '1; M_RW = '1; S_BUS_IN = '1; S_READY = '1;
    M_DONE = '0; M_DONE[w] = 1'b1;
    step();
    chk("done_grant", 32'(M_GRANT), 0);
    chk("done_sel", 32'(S_SEL), 0);
    chk("done_route", 32'({S_BUS_OUT, S_RW, M_BUS_IN, M_READY}), 0);
    M_DONE = '0; M_BUS_OUT = '0; M_RW = '0; S_BUS_IN = '0; S_READY = '0;
    rr_model = (w + 1) % NM;
  endtask

  task automatic do_txn(input logic [NM-1:0] req, input int idx, input int ack, input bit stall,
                        input logic [NM-1:0] eg, input logic [NS-1:0] es, input bit ee);
    int w;
    w = 0;
    for (int i = 0; i < NM; i++) if (eg[i]) w = i;
    M_REQ = req;
    step();
    chk("grant", 32'(M_GRANT), 32'(eg));
    shift_idx(w, idx, stall);
    if (es == '0) begin
      chk("err_decode", 32'(ERR), 32'(ee));
      chk("decode_grant_drop", 32'(M_GRANT), 0);
      chk("decode_no_sel", 32'(S_SEL), 0);
      M_REQ = '0;
      step();
      chk("err_one_cycle", 32'(ERR), 0);
      return;
    end
    chk("sel", 32'(S_SEL), 32'(es));
    chk("no_err_on_sel", 32'(ERR), 0);
    if (ack < 0) begin
      for (int k = 0; k < ACK_TO - 1; k++) begin
        S_ACK = ~es; S_SBSY = ~es;
        step();
      end
      chk("grant_held_to_limit", 32'(M_GRANT), 32'(eg));
      step();
      chk("err_timeout", 32'(ERR), 32'(ee));
      chk("timeout_grant", 32'(M_GRANT), 0);
      chk("timeout_sel", 32'(S_SEL), 0);
      S_ACK = '0; S_SBSY = '0; M_REQ = '0;
      step();
      chk("timeout_err_pulse", 32'(ERR), 0);
      return;
    end
    for (int k = 0; k < ack; k++) begin
      S_ACK = ~es; S_SBSY = ~es;
      step();
    end
    chk("foreign_ack_ignored", 32'(M_ACK), 0);
    S_ACK = es; S_SBSY = '0;
    #1;
    chk("ack_route", 32'(M_ACK), 32'(eg));
    step();
    S_ACK = '0;
    chk("grant_in_xfer", 32'(M_GRANT), 32'(eg));
    xfer_route_done(w, idx);
    M_REQ = '0;
    step();
  endtask

  logic [NM-1:0] rq;
  logic [NS-1:0] r_es;
  int            r_id, r_ak, r_w;
  bit            r_st, r_ee;
  logic [NM-1:0] alt_exp[4];

  initial begin
    tbl[0] = '{2'b01, 2, 0,  0, 2'b01, 3'b100, 0};
    tbl[1] = '{2'b11, 0, 3,  0, 2'b10, 3'b001, 0};
    tbl[2] = '{2'b11, 1, 5,  1, 2'b01, 3'b010, 0};
    tbl[3] = '{2'b01, 3, 0,  0, 2'b01, 3'b000, 1};
    tbl[4] = '{2'b11, 3, 0,  1, 2'b10, 3'b000, 1};
    tbl[5] = '{2'b10, 2, -1, 0, 2'b10, 3'b100, 1};
    tbl[6] = '{2'b01, 1, 15, 0, 2'b01, 3'b010, 0};
    tbl[7] = '{2'b10, 0, 2,  1, 2'b10, 3'b001, 0};
    alt_exp[0] = 2'b01; alt_exp[1] = 2'b10; alt_exp[2] = 2'b01; alt_exp[3] = 2'b10;

    clear_inputs();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("reset_idle_outputs", 32'({M_GRANT, M_BUS_IN, M_READY, M_ACK, M_SPLIT, M_SPL_RESUME,
                                     S_SEL, S_BUS_OUT, S_RW, ERR}), 0);
    end

    // Directed transactions from the vector table
    for (int i = 0; i < 8; i++)
      do_txn(tbl[i].req, tbl[i].idx, tbl[i].ack, tbl[i].stall,
             tbl[i].exp_grant, tbl[i].exp_sel, tbl[i].exp_err);

    // Request dropped mid-shift discards the partial index
    M_REQ = 2'b01;
    step();
    chk("abort_grant_up", 32'(M_GRANT), 32'(2'b01));
    M_UTIL = 2'b01; M_ADD = 2'b01;
    step();
    M_UTIL = '0; M_ADD = '0; M_REQ = '0;
    step();
    chk("abort_grant_drop", 32'(M_GRANT), 0);
    chk("abort_no_sel", 32'(S_SEL), 0);
    chk("abort_no_err", 32'(ERR), 0);
    do_txn(2'b01, 0, 1, 0, 2'b01, 3'b001, 0);

    // Split, another master served, then resume without an address phase
    M_REQ = 2'b10;
    step();
    chk("split_grant_m1", 32'(M_GRANT), 32'(2'b10));
    shift_idx(1, 1, 0);
    chk("split_sel", 32'(S_SEL), 32'(3'b010));
    S_SBSY = 3'b010;
    step();
    chk("split_pulse", 32'(M_SPLIT), 32'(2'b10));
    chk("split_grant_clear", 32'(M_GRANT), 0);
    chk("split_sel_clear", 32'(S_SEL), 0);
    M_REQ = 2'b11;
    step();
    chk("split_pulse_end", 32'(M_SPLIT), 0);
    chk("parked_master_skipped", 32'(M_GRANT), 32'(2'b01));
    shift_idx(0, 2, 0);
    chk("other_sel", 32'(S_SEL), 32'(3'b100));
    S_ACK = 3'b100;
    step();
    S_ACK = '0;
    xfer_route_done(0, 2);
    M_REQ = 2'b10;
    step();
    chk("parked_while_busy", 32'(M_GRANT), 0);
    chk("no_resume_while_busy", 32'(M_SPL_RESUME), 0);
    S_SBSY = '0;
    step();
    chk("resume_pulse", 32'(M_SPL_RESUME), 32'(2'b10));
    chk("resume_grant", 32'(M_GRANT), 32'(2'b10));
    chk("resume_sel", 32'(S_SEL), 32'(3'b010));
    xfer_route_done(1, 1);
    chk("resume_pulse_end", 32'(M_SPL_RESUME), 0);
    M_REQ = '0;
    step();

    // Reset mid-transfer clears everything, including the split record
    M_REQ = 2'b10;
    step();
    shift_idx(1, 1, 0);
    S_SBSY = 3'b010;
    step();
    M_REQ = 2'b11;
    step();
    shift_idx(0, 0, 0);
    S_ACK = 3'b001;
    step();
    chk("pre_reset_grant", 32'(M_GRANT), 32'(2'b01));
    RST = 1'b1;
    #1;
    chk("async_reset_grant", 32'(M_GRANT), 0);
    chk("async_reset_sel", 32'(S_SEL), 0);
    chk("async_reset_route", 32'(M_ACK), 0);
    step();
    RST = 1'b0;
    clear_inputs();
    M_REQ = 2'b10;
    step();
    chk("reset_split_lost", 32'(M_SPL_RESUME), 0);
    chk("reset_normal_grant", 32'(M_GRANT), 32'(2'b10));
    chk("reset_in_addr", 32'(S_SEL), 0);
    M_REQ = '0;
    step();
    chk("reset_abort", 32'(M_GRANT), 0);
    rr_model = 0;

    // Held requests alternate, with one idle cycle between grants
    M_REQ = 2'b11;
    for (int t = 0; t < 4; t++) begin
      step();
      chk("alternate_grant", 32'(M_GRANT), 32'(alt_exp[t]));
      shift_idx(t % 2, 0, 0);
      S_ACK = 3'b001;
      step();
      S_ACK = '0;
      xfer_route_done(t % 2, 0);
    end
    M_REQ = '0;
    step();

    // Randomized transactions against the round-robin model
    for (int t = 0; t < 40; t++) begin
      rq   = NM'($urandom_range(1, (1 << NM) - 1));
      r_id = int'($urandom_range(0, (1 << SW) - 1));
      if ($urandom_range(0, 7) == 0) r_ak = -1;
      else r_ak = int'($urandom_range(0, 10));
      r_st = 1'($urandom_range(0, 1));
      r_w  = model_winner(rq);
      r_es = (r_id < NS) ? (NS'(1) << r_id) : '0;
      r_ee = (r_id >= NS) || (r_ak < 0);
      do_txn(rq, r_id, r_ak, r_st, NM'(1) << r_w, r_es, r_ee);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
